// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among
// NUM_REQ producers. Each grant covers a burst of up to MAX_BURST words or
// until the producer flags its last word. fifo_full is honoured as backpressure.
// Optional build macro ARB_WATCHDOG_EN: revokes a grant whose owner has left
// in_valid low for TIMEOUT consecutive non-full cycles, and pulses timeout_pulse.
module fifo_wr_arbiter #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned MAX_BURST = 16,
   parameter int unsigned TIMEOUT   = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          in_valid,
   input  logic [NUM_REQ-1:0]          in_last,
   input  logic [NUM_REQ*DATA_W-1:0]   in_data,
   output logic [NUM_REQ-1:0]          in_ready,
   input  logic                        fifo_full,
   output logic                        fifo_wr_en,
   output logic [DATA_W-1:0]           fifo_din,
   output logic                        grant_valid,
   output logic [2:0]                  grant_id,
   output logic                        timeout_pulse
);

   localparam int unsigned ID_W  = 3;
   localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] BURST = 1'b1;

   logic [0:0]       state_q, state_d;
   logic             grant_valid_q, grant_valid_d;
   logic [ID_W-1:0]  grant_id_q, grant_id_d;
   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

`ifdef ARB_WATCHDOG_EN
   localparam int unsigned ST_W = $clog2(TIMEOUT + 1);
   logic [ST_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic             timeout_pulse_q, timeout_pulse_d;
`endif

   logic             win_found;
   logic [ID_W-1:0]  win_id;
   logic             gnt_valid;
   logic             gnt_last;
   logic [DATA_W-1:0] gnt_data;
   logic [ID_W-1:0]  next_id;
   logic             beat;
   logic             burst_end;

   // Round-robin pick: first valid requester at or after the pointer, modulo NUM_REQ
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      for (int unsigned p = 0; p < NUM_REQ; p++) begin
         if (ptr_q == ID_W'(p)) begin
            // scan from farthest to nearest so the nearest valid one wins
            for (int unsigned o = NUM_REQ; o > 0; o--) begin
               if (in_valid[(p + o - 1) % NUM_REQ]) begin
                  win_found = 1'b1;
                  win_id    = ID_W'((p + o - 1) % NUM_REQ);
               end
            end
         end
      end
   end

   // Select the granted requester's valid/last/data
   always_comb begin
      gnt_valid = 1'b0;
      gnt_last  = 1'b0;
      gnt_data  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_id_q == ID_W'(i)) begin
            gnt_valid = in_valid[i];
            gnt_last  = in_last[i];
            gnt_data  = in_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Pointer successor of the current grant, wrapping at NUM_REQ
   always_comb begin
      if (grant_id_q >= ID_W'(NUM_REQ - 1)) begin
         next_id = '0;
      end else begin
         next_id = grant_id_q + ID_W'(1);
      end
   end

   assign beat      = (state_q == BURST) && gnt_valid && !fifo_full;
   assign burst_end = beat && (gnt_last || (burst_cnt_q == CNT_W'(MAX_BURST - 1)));

   // Per-requester ready: only the granted requester, and only when the FIFO has room
   always_comb begin
      in_ready = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if ((state_q == BURST) && (grant_id_q == ID_W'(i))) begin
            in_ready[i] = !fifo_full;
         end
      end
   end

   // FIFO write side is driven straight from the granted requester on a beat
   always_comb begin
      fifo_wr_en = beat;
      fifo_din   = (state_q == BURST) ? gnt_data : '0;
   end

   // Next-state logic: arbitration in IDLE, beat counting and release in BURST
   always_comb begin
      state_d       = state_q;
      grant_valid_d = grant_valid_q;
      grant_id_d    = grant_id_q;
      ptr_d         = ptr_q;
      burst_cnt_d   = burst_cnt_q;
`ifdef ARB_WATCHDOG_EN
      stall_cnt_d     = stall_cnt_q;
      timeout_pulse_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
`ifdef ARB_WATCHDOG_EN
            stall_cnt_d = '0;
`endif
            if (win_found) begin
               state_d       = BURST;
               grant_valid_d = 1'b1;
               grant_id_d    = win_id;
               burst_cnt_d   = '0;
            end
         end
         BURST: begin
            if (beat) begin
               burst_cnt_d = burst_cnt_q + CNT_W'(1);
            end
            if (burst_end) begin
               state_d       = IDLE;
               grant_valid_d = 1'b0;
               ptr_d         = next_id;
               burst_cnt_d   = '0;
            end
`ifdef ARB_WATCHDOG_EN
            // only owner-idle cycles count; a full FIFO freezes the count
            if (gnt_valid) begin
               stall_cnt_d = '0;
            end else if (!fifo_full) begin
               if (stall_cnt_q == ST_W'(TIMEOUT - 1)) begin
                  state_d         = IDLE;
                  grant_valid_d   = 1'b0;
                  ptr_d           = next_id;
                  burst_cnt_d     = '0;
                  stall_cnt_d     = '0;
                  timeout_pulse_d = 1'b1;
               end else begin
                  stall_cnt_d = stall_cnt_q + ST_W'(1);
               end
            end
`endif
         end
         default: begin
            state_d       = IDLE;
            grant_valid_d = 1'b0;
         end
      endcase
   end

   // State registers with asynchronous active-high reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         grant_valid_q <= 1'b0;
         grant_id_q    <= '0;
         ptr_q         <= '0;
         burst_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         grant_valid_q <= grant_valid_d;
         grant_id_q    <= grant_id_d;
         ptr_q         <= ptr_d;
         burst_cnt_q   <= burst_cnt_d;
      end
   end

`ifdef ARB_WATCHDOG_EN
   // Watchdog registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q     <= '0;
         timeout_pulse_q <= 1'b0;
      end else begin
         stall_cnt_q     <= stall_cnt_d;
         timeout_pulse_q <= timeout_pulse_d;
      end
   end

   assign timeout_pulse = timeout_pulse_q;
`else
   assign timeout_pulse = 1'b0;
`endif

   assign grant_valid = grant_valid_q;
   assign grant_id    = grant_id_q;

endmodule
